// File: rtl/ecall_io_ctrl.sv
// Ecall I/O sequencer: debounced confirm button, read-int / print-int / exit handling.
// Optional wait-state abort is enabled by defining ECALL_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | no ecall in flight, accepting new ecalls
// WAIT_REL   | ecall accepted, waiting for the debounced button to be released
// WAIT_PRESS | waiting for a fresh debounced press
// SHOW       | print acknowledged, completion pulse on the way out
// HALT       | program exited, frozen until reset
module ecall_io_ctrl #(
    parameter int DEB_CYCLES     = 20,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ecall_valid,
    input  logic [11:0] EcallOp,
    input  logic [31:0] a0_data,
    input  logic        conf_btn,
    input  logic [11:0] switch_data,
    output logic        stall,
    output logic        done,
    output logic        eRead,
    output logic        eWrite,
    output logic [31:0] ecall_rdata,
    output logic [31:0] disp_data,
    output logic        err_op,
    output logic        halted,
    output logic        timeout
);

    localparam logic [11:0] OP_PRINT = 12'd1;
    localparam logic [11:0] OP_READ  = 12'd5;
    localparam logic [11:0] OP_EXIT  = 12'd10;
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    generate
        if (DEB_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_badParam
            $error("ecall_io_ctrl: DEB_CYCLES and TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_REL   = 3'd1,
        WAIT_PRESS = 3'd2,
        SHOW       = 3'd3,
        HALT       = 3'd4
    } ecallState_t;

    ecallState_t state, nextState;

    logic             btnDb, btnDbPrev, press;
    logic [DEB_W-1:0] debCnt;

    logic        opIsRead, opIsReadN;
    logic        doneR, doneN, doneQ;
    logic        eReadR, eReadN;
    logic        eWriteR, eWriteN;
    logic [31:0] rdataR, rdataN;
    logic [31:0] dispR, dispN;

    logic opSupported, idleValid, accept, errOp, holdErr, waiting, timeoutHit;

    always_ff @(posedge clk) begin
        if (rst) begin
            btnDb     <= 1'b0;
            btnDbPrev <= 1'b0;
            debCnt    <= '0;
        end else begin
            btnDbPrev <= btnDb;
            if (conf_btn != btnDb) begin
                if (debCnt >= DEB_W'(DEB_CYCLES - 1)) begin
                    btnDb  <= conf_btn;
                    debCnt <= '0;
                end else begin
                    debCnt <= debCnt + 1'b1;
                end
            end else begin
                debCnt <= '0;
            end
        end
    end

    assign press = btnDb & ~btnDbPrev;

    assign opSupported = (EcallOp == OP_PRINT) || (EcallOp == OP_READ) || (EcallOp == OP_EXIT);
    // The completion cycle releases the pipeline, so the still-present ecall is not re-taken.
    assign idleValid = (state == IDLE) && ecall_valid && !doneR;
    assign accept    = idleValid && opSupported;
    // An unsupported op right after any done pulse is held one cycle to keep pulses apart.
    assign errOp     = idleValid && !opSupported && !doneQ;
    assign holdErr   = idleValid && !opSupported && doneQ;
    assign waiting   = (state == WAIT_REL) || (state == WAIT_PRESS);

`ifdef ECALL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] toCnt;
    logic            timeoutR;

    always_ff @(posedge clk) begin
        if (rst || !waiting) begin
            toCnt <= '0;
        end else if (toCnt < TO_W'(TIMEOUT_CYCLES - 1)) begin
            toCnt <= toCnt + 1'b1;
        end
    end

    // A press landing on the expiry cycle still completes normally.
    assign timeoutHit = waiting && (toCnt == TO_W'(TIMEOUT_CYCLES - 1))
                        && !((state == WAIT_PRESS) && press);

    always_ff @(posedge clk) begin
        if (rst) begin
            timeoutR <= 1'b0;
        end else if (timeoutHit) begin
            timeoutR <= 1'b1;
        end
    end

    assign timeout = timeoutR;
`else
    assign timeoutHit = 1'b0;
    assign timeout    = 1'b0;
`endif

    always_comb begin
        nextState = state;
        doneN     = 1'b0;
        eReadN    = 1'b0;
        eWriteN   = 1'b0;
        rdataN    = rdataR;
        dispN     = dispR;
        opIsReadN = opIsRead;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (EcallOp == OP_READ) begin
                        opIsReadN = 1'b1;
                        nextState = WAIT_REL;
                    end else if (EcallOp == OP_PRINT) begin
                        opIsReadN = 1'b0;
                        dispN     = a0_data;
                        eWriteN   = 1'b1;
                        nextState = WAIT_REL;
                    end else begin
                        nextState = HALT;
                    end
                end
            end
            WAIT_REL: begin
                if (timeoutHit) begin
                    doneN     = 1'b1;
                    nextState = IDLE;
                    if (opIsRead) begin
                        eReadN = 1'b1;
                        rdataN = '0;
                    end
                end else if (!btnDb) begin
                    nextState = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                if (press) begin
                    if (opIsRead) begin
                        rdataN    = {20'h0, switch_data};
                        eReadN    = 1'b1;
                        doneN     = 1'b1;
                        nextState = IDLE;
                    end else begin
                        nextState = SHOW;
                    end
                end else if (timeoutHit) begin
                    doneN     = 1'b1;
                    nextState = IDLE;
                    if (opIsRead) begin
                        eReadN = 1'b1;
                        rdataN = '0;
                    end
                end
            end
            SHOW: begin
                doneN     = 1'b1;
                nextState = IDLE;
            end
            HALT: begin
                nextState = HALT;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            opIsRead <= 1'b0;
            doneR    <= 1'b0;
            doneQ    <= 1'b0;
            eReadR   <= 1'b0;
            eWriteR  <= 1'b0;
            rdataR   <= '0;
            dispR    <= '0;
        end else begin
            state    <= nextState;
            opIsRead <= opIsReadN;
            doneR    <= doneN;
            doneQ    <= done;
            eReadR   <= eReadN;
            eWriteR  <= eWriteN;
            rdataR   <= rdataN;
            dispR    <= dispN;
        end
    end

    assign stall       = accept || holdErr || (state != IDLE);
    assign done        = doneR || errOp;
    assign eRead       = eReadR;
    assign eWrite      = eWriteR;
    assign err_op      = errOp;
    assign ecall_rdata = rdataR;
    assign disp_data   = dispR;
    assign halted      = (state == HALT);

endmodule
